serve_ctrl: RTL and testbench

SERVE_CTRL -- requirements
Module: serve_ctrl

---
 rtl/serve_ctrl.sv | 147 ++++++++++++++
 tb/tb_serve_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serve_ctrl.sv
// rtl/serve_ctrl.sv - serve/freeze sequencer between the score judge and ball physics.
// Optional macro SERVE_BLINK_EN adds a blink output that toggles every 8 frames while held.
module serve_ctrl #(
    parameter int HOLD_FRAMES = 90,
    parameter int P1_SERVE_X  = 250,
    parameter int P2_SERVE_X  = 773,
    parameter int SERVE_Y     = 300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [3:0]  score_player1,
    input  logic [3:0]  score_player2,
    input  logic        flag_point,
    input  logic        endgame,
    output logic [11:0] xpos_serve,
    output logic [11:0] ypos_serve,
    output logic        ball_load,
    output logic        ball_frozen,
    output logic        point_p1,
    output logic        point_p2,
    output logic [1:0]  winner
`ifdef SERVE_BLINK_EN
    ,
    output logic        blink
`endif
);

    typedef enum logic [1:0] {INIT, HOLD, PLAY, OVER} state_t;

    localparam logic [11:0] X1        = 12'(P1_SERVE_X);
    localparam logic [11:0] X2        = 12'(P2_SERVE_X);
    localparam logic [11:0] Y0        = 12'(SERVE_Y);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_FRAMES - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [3:0] sc1_q;
    logic [3:0] sc2_q;
    logic       side;

    logic [3:0] sc1_inc;
    logic [3:0] sc2_inc;
    logic       ev1;
    logic       ev2;
    logic       ev;
    logic       side_nxt;
    logic       serve_ev;
    logic       hold_tick;

    // Only a +1 step (with 4-bit wrap) counts as a point; anything else is a judge resync.
    always_comb begin
        sc1_inc   = sc1_q + 4'd1;
        sc2_inc   = sc2_q + 4'd1;
        ev1       = (score_player1 != sc1_q) && (sc1_inc == score_player1);
        ev2       = (score_player2 != sc2_q) && (sc2_inc == score_player2);
        ev        = ev1 | ev2;
        side_nxt  = side;
        if (ev1 && ev2) begin
            side_nxt = flag_point;
        end else if (ev1) begin
            side_nxt = 1'b0;
        end else if (ev2) begin
            side_nxt = 1'b1;
        end
        serve_ev  = !endgame && ev && (state == HOLD || state == PLAY);
        hold_tick = !endgame && !ev && (state == HOLD) && frame_tick;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= INIT;
            cnt         <= 8'd0;
            sc1_q       <= 4'd0;
            sc2_q       <= 4'd0;
            side        <= 1'b0;
            xpos_serve  <= X1;
            ypos_serve  <= Y0;
            ball_load   <= 1'b0;
            ball_frozen <= 1'b1;
            point_p1    <= 1'b0;
            point_p2    <= 1'b0;
            winner      <= 2'b00;
        end else begin
            sc1_q      <= score_player1;
            sc2_q      <= score_player2;
            point_p1   <= ev1;
            point_p2   <= ev2;
            ball_load  <= 1'b0;
            ypos_serve <= Y0;
            if (endgame && state != OVER) begin
                state       <= OVER;
                ball_frozen <= 1'b1;
                winner      <= (score_player1 > score_player2) ? 2'b01 : 2'b10;
            end else if (serve_ev) begin
                state       <= HOLD;
                cnt         <= 8'd0;
                side        <= side_nxt;
                xpos_serve  <= side_nxt ? X2 : X1;
                ball_load   <= 1'b1;
                ball_frozen <= 1'b1;
            end else begin
                case (state)
                    INIT: begin
                        state       <= HOLD;
                        cnt         <= 8'd0;
                        side        <= 1'b0;
                        xpos_serve  <= X1;
                        ball_load   <= 1'b1;
                        ball_frozen <= 1'b1;
                    end
                    HOLD: begin
                        ball_frozen <= 1'b1;
                        if (hold_tick) begin
                            if (cnt >= HOLD_LAST) begin
                                state       <= PLAY;
                                ball_frozen <= 1'b0;
                            end else if (cnt != 8'hFF) begin
                                cnt <= cnt + 8'd1;
                            end
                        end
                    end
                    PLAY: ball_frozen <= 1'b0;
                    OVER: ball_frozen <= 1'b1;
                endcase
            end
        end
    end

`ifdef SERVE_BLINK_EN
    // Blink restarts dark on every (re)entry to HOLD and is forced dark on exit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink <= 1'b0;
        end else if (state != HOLD || endgame || ev) begin
            blink <= 1'b0;
        end else if (hold_tick) begin
            if (cnt >= HOLD_LAST) begin
                blink <= 1'b0;
            end else if (cnt[2:0] == 3'd7) begin
                blink <= ~blink;
            end
        end
    end
`endif

endmodule

// File: tb/tb_serve_ctrl.sv
// tb/tb_serve_ctrl.sv - self-checking bench for serve_ctrl (vector table plus hold/endgame sequences).
module tb_serve_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic        flag_point = 1'b0;
    logic        endgame = 1'b0;
    logic [3:0]  s1 = 4'd0;
    logic [3:0]  s2 = 4'd0;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        ball_load;
    logic        ball_frozen;
    logic        point_p1;
    logic        point_p2;
    logic [1:0]  winner;
`ifdef SERVE_BLINK_EN
    logic        blink;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    serve_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .score_player1(s1),
        .score_player2(s2),
        .flag_point   (flag_point),
        .endgame      (endgame),
        .xpos_serve   (xpos),
        .ypos_serve   (ypos),
        .ball_load    (ball_load),
        .ball_frozen  (ball_frozen),
        .point_p1     (point_p1),
        .point_p2     (point_p2),
        .winner       (winner)
`ifdef SERVE_BLINK_EN
        ,
        .blink        (blink)
`endif
    );

    typedef struct {
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic        flag;
        logic        e_load;
        logic        e_p1;
        logic        e_p2;
        logic        e_frz;
        logic [11:0] e_x;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic run_hold(input string tag);
        for (int i = 1; i < 90; i++) tick();
        chk({tag, "_frozen_89"}, 16'(ball_frozen), 16'd1);
        tick();
        chk({tag, "_frozen_90"}, 16'(ball_frozen), 16'd0);
    endtask

    initial begin
        tbl[0]  = '{4'd1,  4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'd250};
        tbl[1]  = '{4'd1,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd250};
        tbl[2]  = '{4'd1,  4'd1,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'd773};
        tbl[3]  = '{4'd1,  4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd773};
        tbl[4]  = '{4'd2,  4'd2,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'd250};
        tbl[5]  = '{4'd2,  4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd250};
        tbl[6]  = '{4'd3,  4'd3,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'd773};
        tbl[7]  = '{4'd3,  4'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'd773};
        tbl[8]  = '{4'd0,  4'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'd773};
        tbl[9]  = '{4'd0,  4'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'd773};
        tbl[10] = '{4'd0,  4'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'd773};
        tbl[11] = '{4'd0,  4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd773};
        tbl[12] = '{4'd0,  4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'd773};
        tbl[13] = '{4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd773};

        // Reset state
        step();
        step();
        chk("rst_load", 16'(ball_load), 16'd0);
        chk("rst_p1", 16'(point_p1), 16'd0);
        chk("rst_p2", 16'(point_p2), 16'd0);
        chk("rst_frozen", 16'(ball_frozen), 16'd1);
        chk("rst_winner", 16'(winner), 16'd0);
        chk("rst_x", 16'(xpos), 16'd250);
        chk("rst_y", 16'(ypos), 16'd300);
`ifdef SERVE_BLINK_EN
        chk("rst_blink", 16'(blink), 16'd0);
`endif

        // Release: single load pulse, then 90-tick freeze
        rst = 1'b1;
        step();
        chk("init_load", 16'(ball_load), 16'd1);
        chk("init_x", 16'(xpos), 16'd250);
        chk("init_frozen", 16'(ball_frozen), 16'd1);
        step();
        chk("init_load_end", 16'(ball_load), 16'd0);
        for (int i = 1; i <= 90; i++) begin
            tick();
            chk($sformatf("init_hold_frz_%0d", i), 16'(ball_frozen), (i < 90) ? 16'd1 : 16'd0);
`ifdef SERVE_BLINK_EN
            chk($sformatf("init_blink_%0d", i), 16'(blink), (i < 90) ? 16'((i / 8) % 2) : 16'd0);
`endif
        end

        // Score event table (starts in PLAY)
        for (int v = 0; v < 14; v++) begin
            s1 = tbl[v].s1;
            s2 = tbl[v].s2;
            flag_point = tbl[v].flag;
            step();
            chk($sformatf("vec%0d_load", v), 16'(ball_load), 16'(tbl[v].e_load));
            chk($sformatf("vec%0d_p1", v), 16'(point_p1), 16'(tbl[v].e_p1));
            chk($sformatf("vec%0d_p2", v), 16'(point_p2), 16'(tbl[v].e_p2));
            chk($sformatf("vec%0d_frz", v), 16'(ball_frozen), 16'(tbl[v].e_frz));
            chk($sformatf("vec%0d_x", v), 16'(xpos), 16'(tbl[v].e_x));
        end
        run_hold("tbl_hold");

        // Scores 7 -> 0 in PLAY: resync only
        s1 = 4'd7;
        step();
        s1 = 4'd0;
        step();
        chk("resync_p1", 16'(point_p1), 16'd0);
        chk("resync_load", 16'(ball_load), 16'd0);
        step();
        chk("resync_frozen", 16'(ball_frozen), 16'd0);

        // Player 2 scores 3 -> 4 in PLAY
        s2 = 4'd3;
        step();
        chk("p2pre_p2", 16'(point_p2), 16'd0);
        s2 = 4'd4;
        flag_point = 1'b1;
        step();
        chk("p2_pulse", 16'(point_p2), 16'd1);
        chk("p2_p1", 16'(point_p1), 16'd0);
        chk("p2_load", 16'(ball_load), 16'd1);
        chk("p2_x", 16'(xpos), 16'd773);
        chk("p2_frozen", 16'(ball_frozen), 16'd1);
        step();
        chk("p2_load_end", 16'(ball_load), 16'd0);
        chk("p2_pulse_end", 16'(point_p2), 16'd0);

        // Point during HOLD at tick 40 restarts the freeze
        for (int i = 0; i < 40; i++) tick();
        chk("mid_frozen", 16'(ball_frozen), 16'd1);
        s1 = 4'd1;
        flag_point = 1'b0;
        step();
        chk("mid_p1", 16'(point_p1), 16'd1);
        chk("mid_load", 16'(ball_load), 16'd1);
        chk("mid_x", 16'(xpos), 16'd250);
        run_hold("mid_hold");

        // Endgame 15:9
        s1 = 4'd15;
        s2 = 4'd9;
        step();
        endgame = 1'b1;
        step();
        chk("over_winner", 16'(winner), 16'd1);
        chk("over_frozen", 16'(ball_frozen), 16'd1);
        endgame = 1'b0;
        s2 = 4'd10;
        step();
        chk("over_no_load", 16'(ball_load), 16'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("over_frozen_hold", 16'(ball_frozen), 16'd1);
        chk("over_winner_hold", 16'(winner), 16'd1);
        rst = 1'b0;
        #1;
        chk("over_rst_winner", 16'(winner), 16'd0);
        chk("over_rst_frozen", 16'(ball_frozen), 16'd1);
        chk("over_rst_x", 16'(xpos), 16'd250);

        // Reset aborts a pending load pulse; tie at endgame gives player 2
        s1 = 4'd3;
        s2 = 4'd3;
        step();
        rst = 1'b1;
        step();
        chk("abort_load_pre", 16'(ball_load), 16'd1);
        rst = 1'b0;
        #1;
        chk("abort_load", 16'(ball_load), 16'd0);
        step();
        rst = 1'b1;
        step();
        endgame = 1'b1;
        step();
        chk("tie_winner", 16'(winner), 16'd2);
        chk("tie_frozen", 16'(ball_frozen), 16'd1);
        chk("tie_load", 16'(ball_load), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
